// File: rtl/fetch_queue.sv
// Circular show-ahead instruction FIFO between fetch and decode, with single-cycle flush.
// Optional FETCH_QUEUE_PREDECODE_EN adds a per-entry control-flow flag (deq_is_ctrl_out).
module fetch_queue #(
  parameter int unsigned DEPTH = 8,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             flush_in,
  input  logic             enq_valid_in,
  output logic             enq_ready_out,
  input  logic [31:0]      enq_inst_in,
  input  logic [31:0]      enq_pc_in,
  output logic             deq_valid_out,
  input  logic             deq_ready_in,
  output logic [31:0]      deq_inst_out,
  output logic [31:0]      deq_pc_out,
`ifdef FETCH_QUEUE_PREDECODE_EN
  output logic             deq_is_ctrl_out,
`endif
  output logic [CNT_W-1:0] count_out
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned XLEN  = 32;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  typedef struct packed {
`ifdef FETCH_QUEUE_PREDECODE_EN
    logic            is_ctrl;
`endif
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } entry_t;

  entry_t           mem [DEPTH];
  entry_t           head_entry;
  entry_t           enq_entry;
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;
  logic             enq_fire;
  logic             deq_fire;
  logic             not_empty;

  // Handshakes: ready is purely state-based, valid is masked by flush
  always_comb begin
    not_empty     = (count != '0);
    enq_ready_out = (count != FULL_CNT);
    deq_valid_out = not_empty & ~flush_in;
    enq_fire      = enq_valid_in & enq_ready_out & ~flush_in;
    deq_fire      = deq_valid_out & deq_ready_in;
  end

  // Build the stored entry, including the predecoded control-flow flag when enabled
  always_comb begin
    enq_entry      = '0;
    enq_entry.pc   = enq_pc_in;
    enq_entry.inst = enq_inst_in;
`ifdef FETCH_QUEUE_PREDECODE_EN
    enq_entry.is_ctrl = (enq_inst_in[6:0] == 7'b1100011) ||
                        (enq_inst_in[6:0] == 7'b1101111) ||
                        (enq_inst_in[6:0] == 7'b1100111);
`endif
  end

  // Storage has no reset; empty-state outputs are forced to zero instead
  always_ff @(posedge clk_in) begin
    if (enq_fire) begin
      mem[tail] <= enq_entry;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush_in) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (enq_fire) begin
        tail <= (tail == LAST_PTR) ? '0 : tail + PTR_W'(1);
      end
      if (deq_fire) begin
        head <= (head == LAST_PTR) ? '0 : head + PTR_W'(1);
      end
      count <= count + CNT_W'(enq_fire) - CNT_W'(deq_fire);
    end
  end

  // Show-ahead read of the head entry
  always_comb begin
    head_entry   = mem[head];
    deq_inst_out = not_empty ? head_entry.inst : '0;
    deq_pc_out   = not_empty ? head_entry.pc   : '0;
`ifdef FETCH_QUEUE_PREDECODE_EN
    deq_is_ctrl_out = not_empty ? head_entry.is_ctrl : 1'b0;
`endif
    count_out    = count;
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: stimulus pushes accepted entries, a negedge monitor pops on every deq.
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        enq_valid;
  logic        enq_ready;
  logic [31:0] enq_inst;
  logic [31:0] enq_pc;
  logic        deq_valid;
  logic        deq_ready;
  logic [31:0] deq_inst;
  logic [31:0] deq_pc;
  logic [3:0]  count;
`ifdef FETCH_QUEUE_PREDECODE_EN
  logic        deq_is_ctrl;
`endif

  int passed = 0;
  int total  = 0;
  logic [63:0] sb [$];

  fetch_queue #(.DEPTH(8)) dut (
    .clk_in        (clk),
    .rst_in        (rst),
    .flush_in      (flush),
    .enq_valid_in  (enq_valid),
    .enq_ready_out (enq_ready),
    .enq_inst_in   (enq_inst),
    .enq_pc_in     (enq_pc),
    .deq_valid_out (deq_valid),
    .deq_ready_in  (deq_ready),
    .deq_inst_out  (deq_inst),
    .deq_pc_out    (deq_pc),
`ifdef FETCH_QUEUE_PREDECODE_EN
    .deq_is_ctrl_out (deq_is_ctrl),
`endif
    .count_out     (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive the enqueue side; record an expectation only when the handshake will fire
  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] inst);
    enq_valid = v;
    enq_pc    = pc;
    enq_inst  = inst;
    if (v && enq_ready && !flush) sb.push_back({pc, inst});
  endtask

  // Monitor: every deq handshake must match the oldest expected entry
  always @(negedge clk) begin
    if (!rst && deq_valid && deq_ready) begin
      if (sb.size() == 0) begin
        total++;
        $display("FAIL deq_unexpected: got pc 0x%08h with no entry expected", deq_pc);
      end else begin
        logic [63:0] e;
        e = sb.pop_front();
        chk("deq_pc", deq_pc, e[63:32]);
        chk("deq_inst", deq_inst, e[31:0]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; deq_ready = 1'b0;
    enq_valid = 1'b0; enq_pc = '0; enq_inst = '0;
    #12;
    chk("rst_ready", 32'(enq_ready), 32'd1);
    chk("rst_valid", 32'(deq_valid), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_inst", deq_inst, 32'd0);
    chk("rst_pc", deq_pc, 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // Single entry becomes visible one cycle after the enq edge
    drive(1'b1, 32'h100, 32'h0050_0093);
    tick();
    drive(1'b0, '0, '0);
    chk("t2_valid", 32'(deq_valid), 32'd1);
    chk("t2_inst", deq_inst, 32'h0050_0093);
    chk("t2_pc", deq_pc, 32'h100);
    chk("t2_count", 32'(count), 32'd1);
    deq_ready = 1'b1;
    tick();
    deq_ready = 1'b0;
    chk("t2_drained", 32'(count), 32'd0);

    // Fill to DEPTH, 9th enq refused, drain in order
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 32'(i * 4), 32'hA000_0000 + 32'(i));
      tick();
    end
    drive(1'b0, '0, '0);
    chk("t3_full_count", 32'(count), 32'd8);
    chk("t3_full_ready", 32'(enq_ready), 32'd0);
    drive(1'b1, 32'h20, 32'hA000_0008);
    tick();
    drive(1'b0, '0, '0);
    chk("t3_no_ninth", 32'(count), 32'd8);
    deq_ready = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    deq_ready = 1'b0;
    chk("t3_empty_count", 32'(count), 32'd0);
    chk("t3_empty_valid", 32'(deq_valid), 32'd0);
    chk("t3_empty_inst", deq_inst, 32'd0);
    chk("t3_sb_empty", 32'(sb.size()), 32'd0);

    // Steady state at count 3 with simultaneous enq/deq, pointers wrap
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h1000 + 32'(i * 4), 32'hB000_0000 + 32'(i));
      tick();
    end
    for (int i = 3; i < 23; i++) begin
      drive(1'b1, 32'h1000 + 32'(i * 4), 32'hB000_0000 + 32'(i));
      deq_ready = 1'b1;
      tick();
      chk("t4_count", 32'(count), 32'd3);
    end
    drive(1'b0, '0, '0);
    for (int i = 0; i < 3; i++) tick();
    deq_ready = 1'b0;
    chk("t4_drained", 32'(count), 32'd0);

    // Flush at count 5 with enq and deq requested: everything dropped
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'h2000 + 32'(i * 4), 32'hC000_0000 + 32'(i));
      tick();
    end
    drive(1'b0, '0, '0);
    chk("t5_pre_count", 32'(count), 32'd5);
    flush = 1'b1;
    deq_ready = 1'b1;
    drive(1'b1, 32'h2014, 32'hC000_0005);
    #1;
    chk("t5_valid_masked", 32'(deq_valid), 32'd0);
    tick();
    flush = 1'b0;
    deq_ready = 1'b0;
    drive(1'b0, '0, '0);
    sb.delete();
    chk("t5_count", 32'(count), 32'd0);
    chk("t5_valid", 32'(deq_valid), 32'd0);
    drive(1'b1, 32'h300, 32'h0000_0033);
    tick();
    drive(1'b0, '0, '0);
    chk("t5_post_pc", deq_pc, 32'h300);
    deq_ready = 1'b1;
    tick();
    deq_ready = 1'b0;

`ifdef FETCH_QUEUE_PREDECODE_EN
    // Control-flow predecode follows the head entry
    drive(1'b1, 32'h400, 32'h0000_0063);
    tick();
    drive(1'b1, 32'h404, 32'h0000_0013);
    tick();
    drive(1'b1, 32'h408, 32'h0000_006F);
    tick();
    drive(1'b0, '0, '0);
    chk("t6_beq_ctrl", 32'(deq_is_ctrl), 32'd1);
    deq_ready = 1'b1;
    tick();
    chk("t6_addi_ctrl", 32'(deq_is_ctrl), 32'd0);
    tick();
    chk("t6_jal_ctrl", 32'(deq_is_ctrl), 32'd1);
    tick();
    deq_ready = 1'b0;
    chk("t6_empty_ctrl", 32'(deq_is_ctrl), 32'd0);
`endif

    tick();
    chk("final_sb_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
